// File: rtl/add_pipe_pkg.sv
// Shared types and sizing helpers for the carry-pipelined adder cell.
package add_pipe_pkg;

    localparam int MAXW = 64;

    function automatic int seg_width(input int width, input int stages);
        return (width + stages - 1) / stages;
    endfunction

    function automatic int top_width(input int width, input int stages);
        return width - (stages - 1) * seg_width(width, stages);
    endfunction

    // One pipeline slot: upper operand slices still to be added, lower result already done.
    typedef struct packed {
        logic            valid;
        logic            sub;
        logic            carry;
        logic [MAXW-1:0] a_hi;
        logic [MAXW-1:0] b_hi;
        logic [MAXW-1:0] c_lo;
    } slot_t;

endpackage

// File: rtl/add_pipe_cell_if.sv
// Operand/result handshake bundle for add_pipe_cell.
interface add_pipe_cell_if #(parameter int WIDTH = 8);
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             CIN;
    logic             SUB;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] C;
    logic             COUT;
    logic             OVF;

    modport master (
        output IN_VALID, A, B, CIN, SUB, OUT_READY,
        input  IN_READY, OUT_VALID, C, COUT, OVF
    );

    modport slave (
        input  IN_VALID, A, B, CIN, SUB, OUT_READY,
        output IN_READY, OUT_VALID, C, COUT, OVF
    );
endinterface

// File: rtl/add_pipe_seg.sv
// One W-bit slice of the pipelined adder: registered sum and carry-out.
// Latency: 1 cycle.
// Backpressure: holds its registers while EN is low.
module add_pipe_seg #(
    parameter int W = 4
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         EN,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         CI,
    output logic [W-1:0] S,
    output logic         CO
);
    always_ff @(posedge CLK) begin
        if (RST) begin
            {CO, S} <= '0;
        end else if (EN) begin
            {CO, S} <= {1'b0, A} + {1'b0, B} + (W + 1)'(CI);
        end
    end
endmodule

// File: rtl/add_pipe_cell.sv
// Carry-pipelined adder/subtractor, one segment of carry ripple per cycle.
// Latency: STAGES cycles from the accept edge; one beat per cycle throughput.
// Backpressure: whole pipe stalls as a unit while the result is held; IN_READY = OUT_READY | ~OUT_VALID.
module add_pipe_cell
    import add_pipe_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic          CLK,
    input  logic          RST,
    add_pipe_cell_if.slave io
);
    localparam int SEG  = seg_width(WIDTH, STAGES);
    localparam int TOPW = top_width(WIDTH, STAGES);

    slot_t             slot_q [STAGES];
    slot_t             view   [STAGES];
    slot_t             in_slot;
    slot_t             last;
    logic [WIDTH-1:0]  sum_all;
    logic [STAGES-1:0] cy;
    logic [WIDTH-1:0]  b_eff;
    logic              cin_eff;
    logic              adv;
    logic              acc;

    // Subtract runs as A + ~B + ~CIN so every segment is a plain adder.
    assign b_eff   = io.SUB ? ~io.B : io.B;
    assign cin_eff = io.CIN ^ io.SUB;
    assign adv     = io.OUT_READY | ~io.OUT_VALID;
    assign acc     = io.IN_VALID & adv;

    always_comb begin
        in_slot       = '0;
        in_slot.valid = acc;
        in_slot.sub   = io.SUB;
        in_slot.a_hi  = MAXW'(io.A);
        in_slot.b_hi  = MAXW'(b_eff);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_seg
        localparam int LO = k * SEG;
        localparam int W  = (k == STAGES - 1) ? TOPW : SEG;
        logic [W-1:0] a_in;
        logic [W-1:0] b_in;
        logic [W-1:0] s_out;
        logic         ci;
        logic         co;

        if (k == 0) begin : g_first
            assign a_in = io.A[LO +: W];
            assign b_in = b_eff[LO +: W];
            assign ci   = cin_eff;
        end else begin : g_next
            assign a_in = view[k-1].a_hi[LO +: W];
            assign b_in = view[k-1].b_hi[LO +: W];
            assign ci   = view[k-1].carry;
        end

        add_pipe_seg #(.W(W)) u_seg (
            .CLK (CLK),
            .RST (RST),
            .EN  (adv),
            .A   (a_in),
            .B   (b_in),
            .CI  (ci),
            .S   (s_out),
            .CO  (co)
        );

        assign sum_all[LO +: W] = s_out;
        assign cy[k]            = co;
    end

    // Merge each slot's tag registers with the slice result its segment just produced.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            view[k]       = slot_q[k];
            view[k].carry = cy[k];
            for (int i = 0; i < WIDTH; i++) begin
                if (i / SEG == k) begin
                    view[k].c_lo[i] = sum_all[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                slot_q[k] <= '0;
            end
        end else if (adv) begin
            slot_q[0] <= in_slot;
            for (int k = 1; k < STAGES; k++) begin
                slot_q[k] <= view[k-1];
            end
        end
    end

    assign last         = view[STAGES-1];
    assign io.IN_READY  = adv;
    assign io.OUT_VALID = last.valid;
    assign io.C         = last.c_lo[WIDTH-1:0];
    assign io.COUT      = last.carry;
    assign io.OVF       = (last.a_hi[WIDTH-1] == last.b_hi[WIDTH-1]) &&
                          (last.c_lo[WIDTH-1] != last.a_hi[WIDTH-1]);
endmodule

// File: tb/tb_add_pipe_cell.sv
// Directed and streamed checks of add_pipe_cell in three width/stage configurations.
module tb_add_pipe_cell;

    typedef struct {
        logic [63:0] c;
        logic        cout;
        logic        ovf;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    add_pipe_cell_if #(.WIDTH(8)) if8 ();
    add_pipe_cell_if #(.WIDTH(7)) if7 ();
    add_pipe_cell_if #(.WIDTH(1)) if1 ();

    add_pipe_cell #(.WIDTH(8), .STAGES(2)) u8 (.CLK(clk), .RST(rst), .io(if8));
    add_pipe_cell #(.WIDTH(7), .STAGES(3)) u7 (.CLK(clk), .RST(rst), .io(if7));
    add_pipe_cell #(.WIDTH(1), .STAGES(1)) u1 (.CLK(clk), .RST(rst), .io(if1));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
        end
    endtask

    // Arithmetic reference: unsigned result/borrow and signed range check.
    function automatic res_t ref_op(input int w, input longint a, input longint b,
                                    input longint cin, input bit sub);
        res_t   r;
        longint m, h, u, sa, sb, s;
        m      = longint'(1) << w;
        h      = m / 2;
        u      = sub ? a - b - cin : a + b + cin;
        r.c    = 64'(((u % m) + m) % m);
        r.cout = sub ? (a >= b + cin) : (u >= m);
        sa     = (a >= h) ? a - m : a;
        sb     = (b >= h) ? b - m : b;
        s      = sub ? sa - sb - cin : sa + sb + cin;
        r.ovf  = (s < -h) || (s > h - 1);
        return r;
    endfunction

    task automatic cmp_res(input string tag, input logic [63:0] c, input logic cout,
                           input logic ovf, input res_t e);
        check({tag, ".c"}, c, e.c);
        check({tag, ".cout"}, 64'(cout), 64'(e.cout));
        check({tag, ".ovf"}, 64'(ovf), 64'(e.ovf));
    endtask

    task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic sub,
                        input logic [7:0] ec, input logic ecout, input logic eovf);
        if8.A = a; if8.B = b; if8.CIN = cin; if8.SUB = sub;
        if8.IN_VALID = 1'b1; if8.OUT_READY = 1'b1;
        @(posedge clk); #1;
        if8.IN_VALID = 1'b0;
        check({tag, ".early"}, 64'(if8.OUT_VALID), 64'd0);
        @(posedge clk); #1;
        check({tag, ".valid"}, 64'(if8.OUT_VALID), 64'd1);
        check({tag, ".c"}, 64'(if8.C), 64'(ec));
        check({tag, ".cout"}, 64'(if8.COUT), 64'(ecout));
        check({tag, ".ovf"}, 64'(if8.OVF), 64'(eovf));
    endtask

    logic [7:0] bp_a   [5] = '{8'h05, 8'h05, 8'h80, 8'hC0, 8'h12};
    logic [7:0] bp_b   [5] = '{8'h03, 8'h03, 8'h80, 8'hC0, 8'h34};
    logic       bp_cin [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       bp_sub [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

    initial begin
        res_t       expq[$];
        res_t       e;
        logic [7:0] held_c;
        int         idx, got_n, n_stale;
        int         acc_n, out_n, first_acc, first_out, last_out;
        bit         need_new;

        rst = 1'b1;
        if8.IN_VALID = 0; if8.A = 0; if8.B = 0; if8.CIN = 0; if8.SUB = 0; if8.OUT_READY = 0;
        if7.IN_VALID = 0; if7.A = 0; if7.B = 0; if7.CIN = 0; if7.SUB = 0; if7.OUT_READY = 1;
        if1.IN_VALID = 0; if1.A = 0; if1.B = 0; if1.CIN = 0; if1.SUB = 0; if1.OUT_READY = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset.out_valid", 64'(if8.OUT_VALID), 64'd0);
        check("reset.c", 64'(if8.C), 64'd0);
        check("reset.cout", 64'(if8.COUT), 64'd0);
        check("reset.ovf", 64'(if8.OVF), 64'd0);
        check("reset.out_valid7", 64'(if7.OUT_VALID), 64'd0);
        check("reset.out_valid1", 64'(if1.OUT_VALID), 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("reset.in_ready", 64'(if8.IN_READY), 64'd1);

        // Hand-computed WIDTH=8, STAGES=2 vectors.
        run8("add_wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        run8("sub_ovf",    8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);
        run8("sub_borrow", 8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
        run8("add_ovf",    8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
        run8("sub_bin",    8'h10, 8'h05, 1'b1, 1'b1, 8'h0A, 1'b1, 1'b0);
        run8("add_cin",    8'h3C, 8'h0F, 1'b1, 1'b0, 8'h4C, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: fill with OUT_READY low, hold 5 cycles, release.
        idx = 0; got_n = 0; held_c = '0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if8.OUT_READY = (cyc >= 7);
            if8.IN_VALID  = (idx < 5);
            if (idx < 5) begin
                if8.A = bp_a[idx]; if8.B = bp_b[idx]; if8.CIN = bp_cin[idx]; if8.SUB = bp_sub[idx];
            end
            @(negedge clk);
            if (cyc == 2) begin
                held_c = if8.C;
                check("bp.full", 64'(if8.OUT_VALID), 64'd1);
            end
            if (cyc >= 2 && cyc < 7) begin
                check("bp.in_ready", 64'(if8.IN_READY), 64'd0);
                check("bp.hold_c", 64'(if8.C), 64'(held_c));
            end
            if (if8.IN_VALID && if8.IN_READY) begin
                expq.push_back(ref_op(8, longint'(bp_a[idx]), longint'(bp_b[idx]),
                                      longint'(bp_cin[idx]), bp_sub[idx]));
                idx++;
            end
            if (if8.OUT_VALID && if8.OUT_READY) begin
                check("bp.nonempty", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    cmp_res("bp", 64'(if8.C), if8.COUT, if8.OVF, e);
                end
                got_n++;
            end
            @(posedge clk); #1;
        end
        if8.IN_VALID = 1'b0;
        check("bp.count", 64'(got_n), 64'd5);
        check("bp.leftover", 64'(expq.size()), 64'd0);

        // Reset with two beats in flight.
        if8.OUT_READY = 1'b0;
        if8.A = 8'h11; if8.B = 8'h22; if8.CIN = 0; if8.SUB = 0; if8.IN_VALID = 1'b1;
        @(posedge clk); #1;
        if8.A = 8'h33; if8.B = 8'h44;
        @(posedge clk); #1;
        check("rst.inflight", 64'(if8.OUT_VALID), 64'd1);
        if8.IN_VALID = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst.out_valid", 64'(if8.OUT_VALID), 64'd0);
        check("rst.c", 64'(if8.C), 64'd0);
        check("rst.cout", 64'(if8.COUT), 64'd0);
        check("rst.ovf", 64'(if8.OVF), 64'd0);
        if8.OUT_READY = 1'b1;
        n_stale = 0;
        repeat (3) begin
            @(posedge clk); #1;
            n_stale += int'(if8.OUT_VALID);
        end
        check("rst.no_stale", 64'(n_stale), 64'd0);
        run8("rst.after", 8'h44, 8'h33, 1'b0, 1'b0, 8'h77, 1'b0, 1'b0);
        @(posedge clk); #1;

        // WIDTH=7, STAGES=3: 100 random beats at full rate.
        acc_n = 0; out_n = 0; first_acc = -1; first_out = -1; last_out = -1; need_new = 1;
        for (int cyc = 0; cyc < 200 && out_n < 100; cyc++) begin
            if (need_new && acc_n < 100) begin
                if7.A   = 7'($urandom_range(0, 127));
                if7.B   = 7'($urandom_range(0, 127));
                if7.CIN = 1'($urandom_range(0, 1));
                if7.SUB = 1'($urandom_range(0, 1));
                need_new = 0;
            end
            if7.IN_VALID = (acc_n < 100);
            @(negedge clk);
            if (if7.IN_VALID && if7.IN_READY) begin
                expq.push_back(ref_op(7, longint'(if7.A), longint'(if7.B),
                                      longint'(if7.CIN), if7.SUB));
                if (first_acc < 0) first_acc = cyc;
                acc_n++;
                need_new = 1;
            end
            if (if7.OUT_VALID) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                check("s7.nonempty", 64'(expq.size() != 0), 64'd1);
                if (expq.size() != 0) begin
                    e = expq.pop_front();
                    cmp_res("s7", 64'(if7.C), if7.COUT, if7.OVF, e);
                end
                out_n++;
            end
            @(posedge clk); #1;
        end
        if7.IN_VALID = 1'b0;
        check("s7.count", 64'(out_n), 64'd100);
        check("s7.latency", 64'(first_out - first_acc), 64'd3);
        check("s7.rate", 64'(last_out - first_out), 64'd99);

        // WIDTH=1, STAGES=1.
        if1.A = 1'b1; if1.B = 1'b1; if1.CIN = 1'b1; if1.SUB = 1'b0; if1.IN_VALID = 1'b1;
        @(posedge clk); #1;
        if1.A = 1'b0; if1.B = 1'b1; if1.CIN = 1'b0; if1.SUB = 1'b1;
        check("w1.valid", 64'(if1.OUT_VALID), 64'd1);
        check("w1.c", 64'(if1.C), 64'd1);
        check("w1.cout", 64'(if1.COUT), 64'd1);
        check("w1.ovf", 64'(if1.OVF), 64'd0);
        @(posedge clk); #1;
        if1.IN_VALID = 1'b0;
        check("w1sub.c", 64'(if1.C), 64'd1);
        check("w1sub.cout", 64'(if1.COUT), 64'd0);
        check("w1sub.ovf", 64'(if1.OVF), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
